dffrs_shreg: RTL and testbench
==============================

Name: dffrs_shreg

Overview:
- Parametrised successor to the single-bit D flip-flop with reset/preset: a WIDTH-bit register bank with true and complement outputs.
- Adds a mode-controlled datapath: hold, parallel load, logical shift left/right, rotate left/right, synchronous clear and synchronous preset.
- Adds shifted-out bit capture and a zero flag.
- Used as the general-purpose storage/shift primitive in the lab datapaths, e.g. serialisers, scan-style chains and accumulators.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VALUE, {WIDTH{1'b0}}, value forced by asynchronous reset R.
- PRESET_VALUE, {WIDTH{1'b1}}, value loaded by synchronous preset mode.

Ports:
- CK  input  1  clock; all state updates on rising edge.
- R  input  1  asynchronous reset, active-high.
- EN  input  1  clock enable; 0 = hold regardless of MODE.
- MODE  input  3  operation select (see Behaviour).
- D  input  WIDTH  parallel load data.
- SIL  input  1  serial input for shift left (enters bit 0).
- SIR  input  1  serial input for shift right (enters bit WIDTH-1).
- Q  output  WIDTH  register contents.
- QN  output  WIDTH  bitwise complement of Q, always ~Q.
- SO  output  1  registered bit shifted/rotated out by the last shift/rotate operation.
- ZERO  output  1  combinational, 1 when Q == 0.

Behaviour:
- Async reset: R=1 immediately, with no clock edge, forces:
  - Q=RESET_VALUE, QN=~RESET_VALUE, SO=0.
  - ZERO follows Q.
- R dominates:
  - While R=1, clock edges are ignored.
  - Deassertion of R is not synchronised inside the block.
  - The first edge after R falls performs a normal operation.
- Update rule: on a rising CK with R=0:
  - If EN=0, Q and SO hold.
  - If EN=1, MODE selects the operation.
- MODE encoding:
  - 000 hold: Q and SO unchanged.
  - 001 load: Q<=D; SO unchanged.
  - 010 shift left: Q<={Q[WIDTH-2:0],SIL}; SO<=Q[WIDTH-1].
  - 011 shift right: Q<={SIR,Q[WIDTH-1:1]}; SO<=Q[0].
  - 100 rotate left: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}; SO<=Q[WIDTH-1].
  - 101 rotate right: Q<={Q[0],Q[WIDTH-1:1]}; SO<=Q[0].
  - 110 sync clear: Q<=0; SO unchanged.
  - 111 sync preset: Q<=PRESET_VALUE; SO unchanged.
- Latency: Q, QN and SO reflect an operation one edge after it is sampled. ZERO is combinational from Q and introduces no added latency.
- QN is never stored separately; QN==~Q holds in every cycle, including during reset.
- X handling: MODE containing X/Z with EN=1 drives Q to all-X (simulation-visible fault); synthesis treats it as don't-care.
- Boundary cases:
  - WIDTH rotations in the same direction return Q to its original value.
  - WIDTH shifts left with SIL=0 yield Q=0 and ZERO=1.
  - Mixed shifts with EN toggling: only EN=1 edges count.
- Reset mid-operation: R asserted between edges discards any pending operation. The next enabled edge operates on RESET_VALUE.

Test Plan:
- Reset: R=1 with WIDTH=8, no clock -> Q=8'h00, QN=8'hFF, SO=0, ZERO=1. Release R, EN=0, 3 edges -> Q stays 8'h00.
- Load/hold: EN=1, MODE=001, D=8'hA5, 1 edge -> Q=8'hA5, QN=8'h5A. Then MODE=000 with D=8'h3C, 2 edges -> Q=8'hA5.
- Shift: from Q=8'hA5, MODE=010, SIL=1 -> Q=8'h4B, SO=1. Then MODE=011, SIR=0 -> Q=8'h25, SO=1.
- Rotate: Q=8'h81, MODE=100 -> Q=8'h03, SO=1. Continue 7 more edges -> Q=8'h81.
- Clear/preset and gating: Q=8'h81, MODE=110 -> Q=8'h00, ZERO=1. MODE=111 -> Q=8'hFF, QN=8'h00. EN=0 with MODE=110 -> Q stays 8'hFF.
- Async reset mid-stream: MODE=010 running, assert R 2 ns after an edge -> Q=8'h00 immediately. Release R, SIL=1, 1 edge -> Q=8'h01, SO=0.

Source files
------------

// File: rtl/dffrs_shreg.sv
// WIDTH-bit register bank with true/complement outputs, mode-selected
// load/shift/rotate/clear/preset datapath, shifted-out bit capture and zero flag.
module dffrs_shreg #(
  parameter int unsigned       WIDTH        = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0]  PRESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             CK,
  input  logic             R,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             SO,
  output logic             ZERO
);

  localparam logic [2:0] MODE_HOLD   = 3'b000;
  localparam logic [2:0] MODE_LOAD   = 3'b001;
  localparam logic [2:0] MODE_SHL    = 3'b010;
  localparam logic [2:0] MODE_SHR    = 3'b011;
  localparam logic [2:0] MODE_ROL    = 3'b100;
  localparam logic [2:0] MODE_ROR    = 3'b101;
  localparam logic [2:0] MODE_CLEAR  = 3'b110;
  localparam logic [2:0] MODE_PRESET = 3'b111;

  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;

  always_comb begin
    q_d  = q_q;
    so_d = so_q;
    if (EN) begin
      case (MODE)
        MODE_HOLD:   q_d = q_q;
        MODE_LOAD:   q_d = D;
        MODE_SHL: begin
          q_d  = {q_q[WIDTH-2:0], SIL};
          so_d = q_q[WIDTH-1];
        end
        MODE_SHR: begin
          q_d  = {SIR, q_q[WIDTH-1:1]};
          so_d = q_q[0];
        end
        MODE_ROL: begin
          q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          so_d = q_q[WIDTH-1];
        end
        MODE_ROR: begin
          q_d  = {q_q[0], q_q[WIDTH-1:1]};
          so_d = q_q[0];
        end
        MODE_CLEAR:  q_d = '0;
        MODE_PRESET: q_d = PRESET_VALUE;
        // An unknown MODE poisons the register so the fault is visible in simulation.
        default:     q_d = 'x;
      endcase
    end
  end

  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      q_q  <= RESET_VALUE;
      so_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      so_q <= so_d;
    end
  end

  assign Q    = q_q;
  assign QN   = ~q_q;
  assign SO   = so_q;
  assign ZERO = (q_q == '0);

endmodule

// File: tb/tb_dffrs_shreg.sv
// Bench for dffrs_shreg (WIDTH=8): directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an arithmetic model.
module tb_dffrs_shreg;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         CK = 1'b0;
  logic         R = 1'b0;
  logic         EN = 1'b0;
  logic [2:0]   MODE = 3'b000;
  logic [W-1:0] D = '0;
  logic         SIL = 1'b0;
  logic         SIR = 1'b0;
  logic [W-1:0] Q, QN;
  logic         SO, ZERO;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  int m_q  = 0;
  int m_so = 0;

  dffrs_shreg #(.WIDTH(W)) dut (
    .CK(CK), .R(R), .EN(EN), .MODE(MODE), .D(D), .SIL(SIL), .SIR(SIR),
    .Q(Q), .QN(QN), .SO(SO), .ZERO(ZERO)
  );

  // clock / reset block
  initial forever #5 CK = ~CK;

  // Reference model: register value held as an integer, operations as arithmetic.
  always @(posedge CK or posedge R) begin
    if (R) begin
      m_q  <= 0;
      m_so <= 0;
    end else if (EN) begin
      case (MODE)
        3'd1: m_q <= int'(D);
        3'd2: begin m_q <= (m_q * 2 + int'(SIL)) % MOD;       m_so <= m_q / (MOD / 2); end
        3'd3: begin m_q <= m_q / 2 + int'(SIR) * (MOD / 2);   m_so <= m_q % 2;         end
        3'd4: begin m_q <= (m_q * 2) % MOD + m_q / (MOD / 2); m_so <= m_q / (MOD / 2); end
        3'd5: begin m_q <= m_q / 2 + (m_q % 2) * (MOD / 2);   m_so <= m_q % 2;         end
        3'd6: m_q <= 0;
        3'd7: m_q <= MOD - 1;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard compare process
  always @(negedge CK) begin
    if (cmp_on) begin
      chk("cyc_q",    64'(Q),    64'(m_q));
      chk("cyc_qn",   64'(QN),   64'((MOD - 1) - m_q));
      chk("cyc_so",   64'(SO),   64'(m_so));
      chk("cyc_zero", 64'(ZERO), 64'(m_q == 0));
    end
  end

  // driver: present inputs just after an edge, then advance one edge
  task automatic cyc(input logic en, input logic [2:0] mode, input logic [W-1:0] d,
                     input logic sil, input logic sir);
    EN = en; MODE = mode; D = d; SIL = sil; SIR = sir;
    @(posedge CK);
    #1;
  endtask

  initial begin
    #1 R = 1'b1;
    #1;
    chk("rst_q",    64'(Q),    64'h00);
    chk("rst_qn",   64'(QN),   64'hFF);
    chk("rst_so",   64'(SO),   64'h0);
    chk("rst_zero", 64'(ZERO), 64'h1);
    cmp_on = 1'b1;
    @(posedge CK); #1;
    chk("rst_hold_q", 64'(Q), 64'h00);
    R = 1'b0;

    repeat (3) cyc(1'b0, 3'b001, 8'hFF, 1'b1, 1'b1);
    chk("en0_q", 64'(Q), 64'h00);

    cyc(1'b1, 3'b001, 8'hA5, 1'b0, 1'b0);
    chk("load_q",  64'(Q),  64'hA5);
    chk("load_qn", 64'(QN), 64'h5A);
    repeat (2) cyc(1'b1, 3'b000, 8'h3C, 1'b0, 1'b0);
    chk("hold_q", 64'(Q), 64'hA5);

    cyc(1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
    chk("shl_q",  64'(Q),  64'h4B);
    chk("shl_so", 64'(SO), 64'h1);
    cyc(1'b1, 3'b011, 8'h00, 1'b0, 1'b0);
    chk("shr_q",  64'(Q),  64'h25);
    chk("shr_so", 64'(SO), 64'h1);

    cyc(1'b1, 3'b001, 8'h81, 1'b0, 1'b0);
    cyc(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    chk("rol_q",  64'(Q),  64'h03);
    chk("rol_so", 64'(SO), 64'h1);
    repeat (7) cyc(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    chk("rol8_q", 64'(Q), 64'h81);
    repeat (8) cyc(1'b1, 3'b101, 8'h00, 1'b1, 1'b1);
    chk("ror8_q", 64'(Q), 64'h81);

    cyc(1'b1, 3'b110, 8'h55, 1'b1, 1'b1);
    chk("clr_q",    64'(Q),    64'h00);
    chk("clr_zero", 64'(ZERO), 64'h1);
    cyc(1'b1, 3'b111, 8'h55, 1'b0, 1'b0);
    chk("pre_q",  64'(Q),  64'hFF);
    chk("pre_qn", 64'(QN), 64'h00);
    cyc(1'b0, 3'b110, 8'h55, 1'b0, 1'b0);
    chk("gated_q", 64'(Q), 64'hFF);

    repeat (8) cyc(1'b1, 3'b010, 8'h00, 1'b0, 1'b0);
    chk("shl8_q",    64'(Q),    64'h00);
    chk("shl8_zero", 64'(ZERO), 64'h1);

    cyc(1'b1, 3'b001, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'(i % 2), 3'b010, 8'h00, 1'b0, 1'b0);
    chk("en_toggle_q", 64'(Q), 64'h10);

    cyc(1'b1, 3'b001, 8'hC3, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
    #1 R = 1'b1;
    #1;
    chk("arst_q",    64'(Q),    64'h00);
    chk("arst_qn",   64'(QN),   64'hFF);
    chk("arst_so",   64'(SO),   64'h0);
    chk("arst_zero", 64'(ZERO), 64'h1);
    @(negedge CK); #1;
    R = 1'b0;
    cyc(1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
    chk("post_rst_q",  64'(Q),  64'h01);
    chk("post_rst_so", 64'(SO), 64'h0);

    for (int i = 0; i < 2000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
          1'($urandom), 1'($urandom));
      if ($urandom_range(0, 99) == 0) begin
        #1 R = 1'b1;
        #2 R = 1'b0;
      end
    end

    @(negedge CK); #1;
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
